fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, issues word fetches to instruction memory,
//  buffers returned words in a small FIFO and presents {instr, pc} to decode, which
//  feeds imm_gen. Supports branch/jump redirect with flush and discard of in-flight words.
// PARAMETERS
//  XLEN        32            data/address width
//  RESET_PC    32'h0000_0000 PC of first fetch after reset
//  FIFO_DEPTH  2             instruction buffer entries; power of 2, >= 2
// PORTS
//  clk             in   1     single clock, rising edge
//  rst_n           in   1     asynchronous, active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  XLEN  word-aligned fetch address
//  imem_rsp_valid  in   1     response word valid; in order, no backpressure
//  imem_rsp_data   in   XLEN  response word
//  redirect_valid  in   1     flush and restart fetch at redirect_pc
//  redirect_pc     in   XLEN  new PC; bits [1:0] forced to 0
//  halt            in   1     stop issuing new requests while high
//  instr_valid     out  1     decode-side word valid
//  instr_ready     in   1     decode accepts word
//  instr           out  XLEN  instruction word; 32'h0000_0013 (NOP) when !instr_valid
//  instr_pc        out  XLEN  PC of instr; 0 when !instr_valid
// BEHAVIOUR
//  - Reset: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, FIFO empty,
//    outstanding=0, drop_cnt=0, state=BOOT. Reset mid-transaction abandons everything.
//  - FSM: BOOT -(1 cycle)-> RUN; RUN -halt-> HALT; HALT -!halt-> RUN. redirect_valid
//    in any state loads PC and returns to RUN (HALT if halt also high).
//  - Issue: imem_req_valid=1 in RUN when outstanding+fifo_count < FIFO_DEPTH and
//    !redirect_valid. Handshake on valid&ready; addr/valid held stable until accepted.
//    On accept: pc <= pc+4 (wraps mod 2^XLEN), outstanding++.
//  - Response: word arriving in cycle N appears on instr in N+1 (registered). If
//    drop_cnt>0 word is discarded, drop_cnt--. Each response outstanding--.
//  - Redirect (cycle R): FIFO flushed, instr_valid=0 in R+1, drop_cnt <= outstanding
//    minus any response in R; response in R always dropped; first new request in R+1.
//    Redirect wins over simultaneous instr_ready, request, or response.
//  - Decode handshake: pop on instr_valid&instr_ready; push and pop same cycle on a
//    full FIFO is legal; instr/instr_pc stable while valid&!ready.
//  - Full FIFO with credit exhausted: no request; never overflows, no rsp lost.
//  - HALT: in-flight responses still land in FIFO; decode drains normally.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (words delivered to
//   decode) and perf_stall_cnt[31:0] (cycles instr_valid=0 in RUN); both reset 0, wrap.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared include cpu_defs.vh: XLEN, NOP_INSTR (32'h0000_0013), fetch FSM state
//    encodings (BOOT/RUN/HALT), PC increment constant 4.
//  - One sub-module: fetch_fifo (FIFO of {pc,instr}, WIDTH/DEPTH params, push/pop/
//    flush, count output). Top holds FSM, PC, outstanding and drop counters.
// TESTING
//  1 Reset release, ready=1, 1-cycle mem latency -> addrs 0,4,8...; instr_pc matches.
//  2 instr_ready=0 for 10 cycles -> at most 2 requests; instr/pc held; no word lost.
//  3 Redirect to 0x0000_0103 with 2 outstanding -> both dropped; next req 0x100.
//  4 Redirect same cycle as rsp and instr_ready -> rsp dropped, FIFO empty next cycle.
//  5 halt for 5 cycles -> no new req; in-flight words delivered; resumes at next PC.
//  6 FETCH_PERF_CNT_EN: 8 words consumed, 3 bubbles -> fetch=8, stall=3.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, NOP encoding, PC step and FSM states.
package fetch_unit_pkg;

  localparam int          CPU_XLEN  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_unit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, request issue with credit, in-flight drop after redirect, decode buffer.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN       = CPU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_t      state, state_nxt;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] head;
  logic              credit_ok;
  logic              req_fire;
  logic              push;
  logic              pop;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (halt)  state_nxt = ST_HALT;
      ST_HALT: if (!halt) state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
    if (redirect_valid) state_nxt = halt ? ST_HALT : ST_RUN;
  end

  // Words already requested still need a buffer slot, so they count against the FIFO.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SW'(FIFO_DEPTH);

  assign imem.imem_req_valid = (state == ST_RUN) && !halt && !redirect_valid && credit_ok;
  assign imem.imem_req_addr  = pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  assign push        = imem.imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem.imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= {redirect_pc[XLEN-1:2], 2'b00};
        rsp_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
        // Everything still in flight belongs to the old path; this cycle's response is dropped here.
        drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
      end else begin
        if (req_fire) pc     <= pc + XLEN'(PC_INC);
        if (push)     rsp_pc <= rsp_pc + XLEN'(PC_INC);
        if (imem.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_unit_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rsp_pc, imem.imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (fifo_count)
  );

  assign instr    = instr_valid ? head[XLEN-1:0]      : XLEN'(NOP_INSTR);
  assign instr_pc = instr_valid ? head[2*XLEN-1:XLEN] : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_stall_cnt <= perf_stall_cnt + 32'((state == ST_RUN) && !instr_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random in-order memory model and a stream-level model of the decode output.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) imem ();

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          idx = 0;
  logic [31:0] key = 32'h5A5A_C3C3;
  logic [31:0] exp_pc, exp_req, last_req;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min = 1, lat_max = 1, ready_pct = 100;
  int          req_cnt = 0, pop_cnt = 0, req_since = 0, pop_since = 0;
  logic        prev_hold = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_instr, prev_pc;
  int          model_fetch = 0, model_stall = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ key;
  endfunction

  // One clock cycle: drive inputs, let the memory answer, check outputs, advance the model.
  task automatic cycle(input logic rv, input logic [31:0] rp, input logic hl, input logic ir);
    logic [31:0] a;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt           = hl;
    instr_ready    = ir;
    imem.imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      a = mq_addr.pop_front();
      void'(mq_due.pop_front());
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mem_word(a);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = $urandom;
    end
    #1;
    if (idx >= 1 && !instr_valid) model_stall++;
    if (!instr_valid) begin
      n_cmp++;
      if (instr !== NOP || instr_pc !== 32'h0) begin
        n_err++;
        $display("FAIL idle_out: instr=%h pc=%h, required %h / 0", instr, instr_pc, NOP);
      end
    end
    if (prev_redir) begin
      n_cmp++;
      if (instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush: instr_valid=%b after redirect, required 0", instr_valid);
      end
    end
    if (prev_hold) begin
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_pc) begin
        n_err++;
        $display("FAIL hold: v=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc,
                 prev_instr, prev_pc);
      end
    end
    if (rv || hl) begin
      n_cmp++;
      if (imem.imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL req_block: req_valid=%b during redirect/halt, required 0", imem.imem_req_valid);
      end
    end
    if (instr_valid && ir && !rv) begin
      n_cmp++;
      if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        n_err++;
        $display("FAIL decode: pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, exp_pc,
                 mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      pop_cnt++;
      pop_since++;
      model_fetch++;
    end
    if (imem.imem_req_valid && imem.imem_req_ready) begin
      n_cmp++;
      if (imem.imem_req_addr !== exp_req) begin
        n_err++;
        $display("FAIL req_addr: addr=%h, required %h", imem.imem_req_addr, exp_req);
      end
      last_req = imem.imem_req_addr;
      exp_req  = exp_req + 32'd4;
      req_cnt++;
      req_since++;
      mq_addr.push_back(imem.imem_req_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (rv) begin
      exp_pc    = {rp[31:2], 2'b00};
      exp_req   = {rp[31:2], 2'b00};
      req_since = 0;
      pop_since = 0;
    end
    prev_redir = rv;
    prev_hold  = instr_valid && !ir && !rv;
    prev_instr = instr;
    prev_pc    = instr_pc;
    @(posedge clk);
    #1;
    cyc++;
    idx++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    instr_ready = 1'b0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = '0;
    mq_addr.delete();
    mq_due.delete();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (imem.imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req_valid: %b, required 0", imem.imem_req_valid);
    end
    n_cmp++;
    if (imem.imem_req_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL rst_req_addr: %h, required %h", imem.imem_req_addr, RESET_PC);
    end
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
      n_err++;
      $display("FAIL rst_decode: v=%b instr=%h pc=%h, required 0 %h 0", instr_valid, instr, instr_pc, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL rst_perf: fetch=%0d stall=%0d, required 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    rst_n = 1'b1;
    cyc = 0;
    idx = 0;
    exp_pc = RESET_PC;
    exp_req = RESET_PC;
    prev_hold = 1'b0;
    prev_redir = 1'b0;
    req_since = 0;
    pop_since = 0;
    model_fetch = 0;
    model_stall = 0;
  endtask

  task automatic test_sequential();
    int p0;
    lat_min = 1; lat_max = 1; ready_pct = 100;
    p0 = pop_cnt;
    for (int i = 0; i < 24; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (pop_cnt - p0 < 8) begin
      n_err++;
      $display("FAIL seq_progress: %0d words in 24 cycles, required >= 8", pop_cnt - p0);
    end
  endtask

  task automatic test_backpressure();
    int r0, p0;
    r0 = req_cnt;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (req_cnt - r0 > DEPTH) begin
      n_err++;
      $display("FAIL bp_requests: %0d requests while stalled, required <= %0d", req_cnt - r0, DEPTH);
    end
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (pop_cnt - p0 < 3) begin
      n_err++;
      $display("FAIL bp_resume: %0d words after release, required >= 3", pop_cnt - p0);
    end
  endtask

  task automatic test_redirect_drop();
    int n, r0;
    lat_min = 3; lat_max = 3; ready_pct = 100;
    n = 0;
    while (mq_addr.size() != 2 && n < 20) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    n_cmp++;
    if (mq_addr.size() != 2) begin
      n_err++;
      $display("FAIL wait_outstanding: %0d in flight, required 2", mq_addr.size());
    end
    cycle(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    r0 = req_cnt;
    n = 0;
    while (req_cnt == r0 && n < 20) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    n_cmp++;
    if (req_cnt == r0 || last_req !== 32'h0000_0100) begin
      n_err++;
      $display("FAIL redirect_addr: first req %h (count %0d), required 00000100", last_req, req_cnt - r0);
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (pop_since < 2) begin
      n_err++;
      $display("FAIL redirect_resume: %0d words from new path, required >= 2", pop_since);
    end
  endtask

  task automatic test_redirect_collision();
    int n;
    logic [31:0] tgt;
    lat_min = 1; lat_max = 1; ready_pct = 100;
    n = 0;
    while (!(mq_addr.size() > 0 && mq_due[0] <= cyc && instr_valid) && n < 30) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    n_cmp++;
    if (n >= 30) begin
      n_err++;
      $display("FAIL collision_setup: no rsp+valid cycle within %0d cycles, required one", n);
    end
    tgt = $urandom & 32'h0000_FFFC;
    cycle(1'b1, tgt, 1'b0, 1'b1);
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL collision_empty: instr_valid=%b, required 0", instr_valid);
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_halt();
    int r0;
    lat_min = 2; lat_max = 2; ready_pct = 100;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    n_cmp++;
    if (req_cnt != r0) begin
      n_err++;
      $display("FAIL halt_req: %0d requests while halted, required 0", req_cnt - r0);
    end
    n_cmp++;
    if (pop_since != req_since) begin
      n_err++;
      $display("FAIL halt_drain: %0d delivered of %0d requested, required equal", pop_since, req_since);
    end
    r0 = req_cnt;
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (req_cnt == r0) begin
      n_err++;
      $display("FAIL halt_resume: %0d requests after halt, required > 0", req_cnt - r0);
    end
  endtask

  task automatic test_random();
    logic hl, rv;
    lat_min = 1; lat_max = 4; ready_pct = 70;
    hl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 8) hl = ~hl;
      rv = ($urandom_range(99) < 4);
      cycle(rv, $urandom, hl, ($urandom_range(99) < 75));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    lat_min = 3; lat_max = 3; ready_pct = 100;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    test_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (pop_since < 6) begin
      n_err++;
      $display("FAIL reset_restart: %0d words after mid reset, required >= 6", pop_since);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    test_reset();
    lat_min = 1; lat_max = 2; ready_pct = 100;
    for (int i = 0; i < 30; i++) cycle(1'b0, '0, 1'b0, ($urandom_range(99) < 70));
    n_cmp++;
    if (perf_fetch_cnt !== 32'(model_fetch)) begin
      n_err++;
      $display("FAIL perf_fetch: %0d, required %0d", perf_fetch_cnt, model_fetch);
    end
    n_cmp++;
    if (perf_stall_cnt !== 32'(model_stall)) begin
      n_err++;
      $display("FAIL perf_stall: %0d, required %0d", perf_stall_cnt, model_stall);
    end
  endtask
`endif

  initial begin
    key = $urandom;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_halt();
    test_random();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
